// File: rtl/conv_tile_scheduler.sv
// Per-layer sequencer for the convolution kernel controller.
// It holds the kernel in reset while the layer configuration is latched.
// It then issues one conv_compute pulse per output tile, but only when a filled input buffer is
// available and writeback has no tile still pending.
// It also tracks credits for the input-buffer ring, requests loader fills, and presents each
// finished tile to writeback.
// Optional feature: define SCHED_PERF_CNT_EN to enable the stall_cnt performance counter.
module conv_tile_scheduler #(
  parameter int unsigned BuffersNum = 3,
  parameter int unsigned CfgCycles  = 2,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                layer_start_i,
  output logic                buf_fill_req_o,
  input  logic                buf_fill_done_i,
  output logic                kernel_reset_o,
  output logic                conv_compute_o,
  input  logic                conv_nif_add_end_i,
  input  logic                com_control_end_i,
  output logic                tile_valid_o,
  input  logic                tile_ready_i,
  output logic [2:0]          buf_filled_o,
  output logic                busy_o,
  output logic                layer_done_o,
  output logic                ovf_err_o,
  output logic [CntWidth-1:0] tile_cnt_o,
  output logic [CntWidth-1:0] stall_cnt_o
);

  localparam int unsigned CfgW = (CfgCycles > 1) ? $clog2(CfgCycles) : 1;
  localparam logic [CfgW-1:0] CfgLast = CfgW'(CfgCycles - 1);
  localparam logic [2:0] BufMax = 3'(BuffersNum);

  typedef enum logic [2:0] {StIdle, StCfg, StWait, StIssue, StRun, StFinish} state_e;

  state_e              state_q, state_d;
  logic [CfgW-1:0]     cfg_cnt_q, cfg_cnt_d;
  logic [2:0]          buf_filled_q, buf_filled_d;
  logic                inflight_q, inflight_d;
  logic                tile_valid_q, tile_valid_d;
  logic                ovf_q, ovf_d;
  logic [CntWidth-1:0] tile_cnt_q, tile_cnt_d;

  logic       busy;
  logic       fill_req;
  logic       release_buf;
  logic       start;
  logic       issue_go;
  logic [3:0] credits;

  assign busy        = (state_q != StIdle);
  assign credits     = {1'b0, buf_filled_q} + {3'b000, inflight_q};
  assign fill_req    = busy && (state_q != StCfg) && (credits < 4'(BuffersNum));
  assign release_buf = (state_q == StRun) && conv_nif_add_end_i;
  assign start       = (state_q == StIdle) && layer_start_i;
  // A new tile may only start once the previous result has been handed to writeback.
  assign issue_go    = (state_q == StWait) && (buf_filled_q != 3'd0) && !tile_valid_q;

  // Layer sequencing: next state and config-hold counter.
  always_comb begin
    state_d   = state_q;
    cfg_cnt_d = cfg_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (layer_start_i) begin
          state_d   = StCfg;
          cfg_cnt_d = '0;
        end
      end
      StCfg: begin
        if (cfg_cnt_q == CfgLast) begin
          state_d = StWait;
        end else begin
          cfg_cnt_d = cfg_cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (issue_go) state_d = StIssue;
      end
      StIssue: begin
        state_d = StRun;
      end
      StRun: begin
        // com_control_end only counts when it accompanies the tile-end strobe.
        if (conv_nif_add_end_i) state_d = com_control_end_i ? StFinish : StWait;
      end
      StFinish: begin
        if (!tile_valid_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Buffer credits, loader handshake, tile handoff and tile counter.
  always_comb begin
    buf_filled_d = buf_filled_q;
    ovf_d        = ovf_q | (buf_fill_done_i && (buf_filled_q == BufMax));
    if (start) begin
      buf_filled_d = 3'd0;
    end else if (buf_fill_done_i && !release_buf) begin
      if (buf_filled_q != BufMax) buf_filled_d = buf_filled_q + 3'd1;
    end else if (release_buf && !buf_fill_done_i) begin
      if (buf_filled_q != 3'd0) buf_filled_d = buf_filled_q - 3'd1;
    end

    // At most one fill outstanding at a time; completion wins over a new request.
    inflight_d = inflight_q;
    if (buf_fill_done_i) begin
      inflight_d = 1'b0;
    end else if (fill_req) begin
      inflight_d = 1'b1;
    end

    // A tile finishing in the same cycle as a handshake keeps tile_valid set.
    tile_valid_d = tile_valid_q;
    if (release_buf) begin
      tile_valid_d = 1'b1;
    end else if (tile_valid_q && tile_ready_i) begin
      tile_valid_d = 1'b0;
    end

    tile_cnt_d = tile_cnt_q;
    if (start) begin
      tile_cnt_d = '0;
    end else if (issue_go) begin
      tile_cnt_d = tile_cnt_q + 1'b1;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cfg_cnt_q    <= '0;
      buf_filled_q <= 3'd0;
      inflight_q   <= 1'b0;
      tile_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      tile_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cfg_cnt_q    <= cfg_cnt_d;
      buf_filled_q <= buf_filled_d;
      inflight_q   <= inflight_d;
      tile_valid_q <= tile_valid_d;
      ovf_q        <= ovf_d;
      tile_cnt_q   <= tile_cnt_d;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;

  // Count cycles spent waiting for a buffer or for writeback.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start) begin
      stall_cnt_d = '0;
    end else if (state_q == StWait) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign buf_fill_req_o = fill_req;
  assign kernel_reset_o = (state_q == StIdle) || (state_q == StCfg);
  assign conv_compute_o = (state_q == StIssue);
  assign tile_valid_o   = tile_valid_q;
  assign buf_filled_o   = buf_filled_q;
  assign busy_o         = busy;
  assign layer_done_o   = (state_q == StFinish) && !tile_valid_q;
  assign ovf_err_o      = ovf_q;
  assign tile_cnt_o     = tile_cnt_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Self-checking bench for conv_tile_scheduler.
// A behavioural layer model predicts every output each cycle.
// Directed sequences pin the model with literal expectations.
module tb_conv_tile_scheduler;

  localparam int N    = 3;
  localparam int CFGC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        layer_start = 1'b0;
  logic        fill_done = 1'b0;
  logic        nif_end = 1'b0;
  logic        com_end = 1'b0;
  logic        tile_ready = 1'b0;
  logic        buf_fill_req, kernel_reset, conv_compute, tile_valid;
  logic        busy, layer_done, ovf_err;
  logic [2:0]  buf_filled;
  logic [15:0] tile_cnt, stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  conv_tile_scheduler dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .layer_start_i      (layer_start),
    .buf_fill_req_o     (buf_fill_req),
    .buf_fill_done_i    (fill_done),
    .kernel_reset_o     (kernel_reset),
    .conv_compute_o     (conv_compute),
    .conv_nif_add_end_i (nif_end),
    .com_control_end_i  (com_end),
    .tile_valid_o       (tile_valid),
    .tile_ready_i       (tile_ready),
    .buf_filled_o       (buf_filled),
    .busy_o             (busy),
    .layer_done_o       (layer_done),
    .ovf_err_o          (ovf_err),
    .tile_cnt_o         (tile_cnt),
    .stall_cnt_o        (stall_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_CFG = 1, PH_WAIT = 2, PH_ISSUE = 3, PH_RUN = 4, PH_FINISH = 5;

  int          m_ph, m_cfg_left, m_filled;
  bit          m_infl, m_tv, m_ovf;
  logic [15:0] m_tcnt, m_stall;

  int          nx_ph, nx_cfg_left, nx_filled;
  bit          nx_infl, nx_tv, nx_ovf;
  logic [15:0] nx_tcnt, nx_stall;
  bit          e_busy, e_kr, e_cc, e_done, e_req, rel, start;

  always_comb begin
    e_busy = (m_ph != PH_IDLE);
    e_kr   = (m_ph == PH_IDLE) || (m_ph == PH_CFG);
    e_cc   = (m_ph == PH_ISSUE);
    e_done = (m_ph == PH_FINISH) && !m_tv;
    e_req  = e_busy && (m_ph != PH_CFG) && (m_filled + int'(m_infl) < N);
    rel    = (m_ph == PH_RUN) && nif_end;
    start  = (m_ph == PH_IDLE) && layer_start;

    nx_ph       = m_ph;
    nx_cfg_left = m_cfg_left;
    case (m_ph)
      PH_IDLE:   if (layer_start) begin nx_ph = PH_CFG; nx_cfg_left = CFGC; end
      PH_CFG:    if (m_cfg_left <= 1) nx_ph = PH_WAIT; else nx_cfg_left = m_cfg_left - 1;
      PH_WAIT:   if (m_filled > 0 && !m_tv) nx_ph = PH_ISSUE;
      PH_ISSUE:  nx_ph = PH_RUN;
      PH_RUN:    if (nif_end) nx_ph = com_end ? PH_FINISH : PH_WAIT;
      default:   if (!m_tv) nx_ph = PH_IDLE;
    endcase

    nx_filled = m_filled + int'(fill_done) - int'(rel);
    if (nx_filled > N) nx_filled = N;
    if (nx_filled < 0) nx_filled = 0;
    if (start) nx_filled = 0;
    nx_ovf  = m_ovf || (fill_done && m_filled == N);
    nx_infl = fill_done ? 1'b0 : (e_req ? 1'b1 : m_infl);
    nx_tv   = rel ? 1'b1 : ((m_tv && tile_ready) ? 1'b0 : m_tv);
    nx_tcnt = start ? 16'd0 : ((m_ph == PH_WAIT && m_filled > 0 && !m_tv) ? m_tcnt + 16'd1 : m_tcnt);
`ifdef SCHED_PERF_CNT_EN
    nx_stall = start ? 16'd0 : ((m_ph == PH_WAIT) ? m_stall + 16'd1 : m_stall);
`else
    nx_stall = 16'd0;
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= PH_IDLE; m_cfg_left <= 0; m_filled <= 0; m_infl <= 1'b0;
      m_tv <= 1'b0; m_ovf <= 1'b0; m_tcnt <= 16'd0; m_stall <= 16'd0;
    end else begin
      m_ph <= nx_ph; m_cfg_left <= nx_cfg_left; m_filled <= nx_filled; m_infl <= nx_infl;
      m_tv <= nx_tv; m_ovf <= nx_ovf; m_tcnt <= nx_tcnt; m_stall <= nx_stall;
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("kernel_reset", kernel_reset, e_kr);
      chk("conv_compute", conv_compute, e_cc);
      chk("layer_done", layer_done, e_done);
      chk("buf_fill_req", buf_fill_req, e_req);
      chk("buf_filled", buf_filled, m_filled);
      chk("tile_valid", tile_valid, m_tv);
      chk("ovf_err", ovf_err, m_ovf);
      chk("tile_cnt", tile_cnt, m_tcnt);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("cc_while_kr", conv_compute && kernel_reset, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; layer_start = 0; fill_done = 0; nif_end = 0; com_end = 0; tile_ready = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_kernel_reset", kernel_reset, 1);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_buf_filled", buf_filled, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_tile_valid", tile_valid, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_layer(input int tiles, input bit abort);
    int  issued = 0;
    int  kdelay = 0;
    bit  pending = 1'b0;
    bit  done = 1'b0;
    int  cyc = 0;
    layer_start = 1'b1;
    step();
    layer_start = 1'b0;
    while (!done && cyc < 3000) begin
      if (layer_done) begin
        done = 1'b1;
        fill_done = 0; nif_end = 0; com_end = 0;
        break;
      end
      if (abort && issued == 2 && pending) begin
        // Reset while the kernel is running a tile.
        rst_n = 1'b0; fill_done = 0; nif_end = 0; com_end = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_layer_done", layer_done, 0);
        chk("abort_kernel_reset", kernel_reset, 1);
        chk("abort_buf_filled", buf_filled, 0);
        step();
        rst_n = 1'b1;
        step();
        return;
      end
      fill_done  = (buf_fill_req && $urandom_range(2) == 0) || ($urandom_range(59) == 0);
      tile_ready = ($urandom_range(3) != 0);
      nif_end    = 1'b0;
      com_end    = ($urandom_range(19) == 0);
      if (pending) begin
        kdelay--;
        if (kdelay == 0) begin
          nif_end = 1'b1;
          com_end = (issued >= tiles);
          pending = 1'b0;
        end
      end else if (conv_compute) begin
        issued++;
        pending = 1'b1;
        kdelay = $urandom_range(5, 1);
      end else if ($urandom_range(24) == 0) begin
        nif_end = 1'b1;  // outside RUN: must be ignored
      end
      step();
      cyc++;
    end
    chk("layer_completed", done, 1);
    chk("layer_tiles", tile_cnt, tiles);
    step();
    chk("idle_after_layer", busy, 0);
    repeat (2) step();
  endtask

  initial begin
    int cc;
    step();
    chk_en = 1'b1;
    do_reset();

    // Single tile layer with hand-computed timing.
    layer_start = 1'b1; step(); layer_start = 1'b0;
    chk("t1_busy", busy, 1); chk("t1_kr_cfg0", kernel_reset, 1); chk("t1_req_cfg", buf_fill_req, 0);
    step();
    chk("t1_kr_cfg1", kernel_reset, 1);
    step();
    chk("t1_kr_low", kernel_reset, 0); chk("t1_req", buf_fill_req, 1);
    fill_done = 1'b1; step(); fill_done = 1'b0;
    chk("t1_filled1", buf_filled, 1); chk("t1_cc_early", conv_compute, 0);
    step();
    chk("t1_cc", conv_compute, 1); chk("t1_tcnt", tile_cnt, 1);
    step();
    chk("t1_cc_pulse", conv_compute, 0);
    nif_end = 1'b1; com_end = 1'b1; tile_ready = 1'b1; step(); nif_end = 1'b0; com_end = 1'b0;
    chk("t1_tv", tile_valid, 1); chk("t1_filled0", buf_filled, 0); chk("t1_done_early", layer_done, 0);
    step();
    chk("t1_tv_clr", tile_valid, 0); chk("t1_done", layer_done, 1);
    step();
    chk("t1_done_pulse", layer_done, 0); chk("t1_idle", busy, 0); chk("t1_tcnt_end", tile_cnt, 1);
    do_reset();

    // Simultaneous fill/release, saturation, sticky overflow, writeback back-pressure.
    layer_start = 1'b1; step(); layer_start = 1'b0;
    step(); step();
    fill_done = 1'b1; step(); step();
    fill_done = 1'b0;
    chk("t4_cc", conv_compute, 1); chk("t4_filled2", buf_filled, 2);
    step();
    fill_done = 1'b1; nif_end = 1'b1; tile_ready = 1'b0; step(); nif_end = 1'b0;
    chk("t4_same_cycle", buf_filled, 2); chk("t4_tv", tile_valid, 1);
    step();
    chk("t5_filled3", buf_filled, 3); chk("t5_no_ovf", ovf_err, 0);
    step(); fill_done = 1'b0;
    chk("t5_sat", buf_filled, 3); chk("t5_ovf", ovf_err, 1);
    cc = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (conv_compute) cc++;
    end
    chk("t3_no_issue", cc, 0); chk("t5_ovf_sticky", ovf_err, 1);
`ifdef SCHED_PERF_CNT_EN
    chk("t3_stall_ge30", stall_cnt >= 16'd30, 1);
`else
    chk("t3_stall_off", stall_cnt, 0);
`endif
    tile_ready = 1'b1; step(); step();
    chk("t3_issue_after_hs", conv_compute, 1); chk("t3_tcnt", tile_cnt, 2);
    do_reset();

    // Randomized layers; one is cut short by reset mid-tile.
    for (int l = 0; l < 8; l++) begin
      run_layer($urandom_range(5, 1), l == 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
